// File: rtl/mult_inverse.sv
// Modular multiplicative inverse: computes x with (a*x) mod m = 1 using
// extended Euclid. A single one-bit-per-cycle restoring divider is shared by
// the initial reduction of a and by every Euclid quotient step.
//
// Handshake: an input or output word transfers on a rising edge where its
// tvalid and tready are both 1. The two operands transfer together. tready is
// held high only in IDLE. A result, once valid, is held stable until accepted.
module mult_inverse #(
  parameter int SIZE = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] input_base_tdata,
  input  logic            input_base_tvalid,
  output logic            input_base_tready,
  input  logic [SIZE-1:0] input_modulus_tdata,
  input  logic            input_modulus_tvalid,
  output logic            input_modulus_tready,
  output logic [SIZE-1:0] output_tdata,
  output logic            output_tvalid,
  input  logic            output_tready,
  output logic [2:0]      state_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REDUCE = 3'd1,
    DIVIDE = 3'd2,
    UPDATE = 3'd3,
    FIXUP  = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam int CW = $clog2(SIZE + 1);

  state_t state_q, state_d;

  // Euclid remainders, modulus and result
  logic [SIZE-1:0] r0_q, r0_d, r1_q, r1_d;
  logic [SIZE-1:0] m_q, m_d, res_q, res_d;
  // Bezout coefficients; |t| never exceeds m, so SIZE+1 signed bits suffice
  logic signed [SIZE:0] t0_q, t0_d, t1_q, t1_d;
  // Divider: dq holds dividend bits shifting out and quotient bits shifting in
  logic [SIZE-1:0] dq_q, dq_d, dr_q, dr_d, dd_q, dd_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [SIZE:0]   div_shift;
  logic [SIZE-1:0] div_diff;
  logic            div_ge;
  logic [SIZE-1:0] step_rem, step_quo;
  logic            div_last;
  logic [SIZE:0]   prod_lo;
  logic [SIZE:0]   fix_sum;

  // One restoring-division step on the current divider registers
  always_comb begin
    div_shift = {dr_q, dq_q[SIZE-1]};
    div_ge    = (div_shift >= {1'b0, dd_q});
    // When div_ge holds the true difference is below dd, so SIZE bits are exact
    div_diff  = div_shift[SIZE-1:0] - dd_q;
    step_rem  = div_ge ? div_diff : div_shift[SIZE-1:0];
    step_quo  = {dq_q[SIZE-2:0], div_ge};
  end

  assign div_last = (cnt_q == CW'(SIZE - 1));
  // Only the low SIZE+1 bits of q*t1 are needed: the true t0-q*t1 fits there
  assign prod_lo  = {1'b0, dq_q} * t1_q;
  assign fix_sum  = t0_q + {1'b0, m_q};

  assign input_base_tready    = (state_q == IDLE) && rst;
  assign input_modulus_tready = (state_q == IDLE) && rst;
  assign output_tvalid        = (state_q == DONE);
  assign output_tdata         = res_q;
  assign state_o              = state_q;

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    r0_d    = r0_q;
    r1_d    = r1_q;
    m_d     = m_q;
    res_d   = res_q;
    t0_d    = t0_q;
    t1_d    = t1_q;
    dq_d    = dq_q;
    dr_d    = dr_q;
    dd_d    = dd_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (input_base_tvalid && input_modulus_tvalid) begin
          dq_d    = input_base_tdata;
          dr_d    = '0;
          dd_d    = input_modulus_tdata;
          m_d     = input_modulus_tdata;
          cnt_d   = '0;
          state_d = REDUCE;
        end
      end
      REDUCE: begin
        dq_d  = step_quo;
        dr_d  = step_rem;
        cnt_d = cnt_q + CW'(1);
        if (div_last) begin
          r0_d = m_q;
          r1_d = step_rem;
          t0_d = '0;
          t1_d = {{SIZE{1'b0}}, 1'b1};
          if ((m_q <= SIZE'(1)) || (step_rem == '0)) begin
            state_d = FIXUP;
          end else begin
            dq_d    = m_q;
            dr_d    = '0;
            dd_d    = step_rem;
            cnt_d   = '0;
            state_d = DIVIDE;
          end
        end
      end
      DIVIDE: begin
        dq_d  = step_quo;
        dr_d  = step_rem;
        cnt_d = cnt_q + CW'(1);
        if (div_last) begin
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        // dq now holds the quotient, dr the remainder r0 - q*r1
        r0_d = r1_q;
        r1_d = dr_q;
        t0_d = t1_q;
        t1_d = t0_q - $signed(prod_lo);
        if (dr_q == '0) begin
          state_d = FIXUP;
        end else begin
          dq_d    = r1_q;
          dd_d    = dr_q;
          dr_d    = '0;
          cnt_d   = '0;
          state_d = DIVIDE;
        end
      end
      FIXUP: begin
        if (r0_q == SIZE'(1)) begin
          res_d = t0_q[SIZE] ? fix_sum[SIZE-1:0] : t0_q[SIZE-1:0];
        end else begin
          res_d = '0;
        end
        state_d = DONE;
      end
      DONE: begin
        if (output_tready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      r0_q    <= '0;
      r1_q    <= '0;
      m_q     <= '0;
      res_q   <= '0;
      t0_q    <= '0;
      t1_q    <= '0;
      dq_q    <= '0;
      dr_q    <= '0;
      dd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      r0_q    <= r0_d;
      r1_q    <= r1_d;
      m_q     <= m_d;
      res_q   <= res_d;
      t0_q    <= t0_d;
      t1_q    <= t1_d;
      dq_q    <= dq_d;
      dr_q    <= dr_d;
      dd_q    <= dd_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mult_inverse.sv
// Bench for mult_inverse: directed cases, hold/back-pressure, mid-operation
// reset, and randomized operands against an extended-Euclid reference.
module tb_mult_inverse;

  localparam int SIZE    = 32;
  localparam int MAX_LAT = (SIZE + 2) * (2 * SIZE + 3);

  logic            clk;
  logic            rst;
  logic [SIZE-1:0] input_base_tdata;
  logic            input_base_tvalid;
  logic            input_base_tready;
  logic [SIZE-1:0] input_modulus_tdata;
  logic            input_modulus_tvalid;
  logic            input_modulus_tready;
  logic [SIZE-1:0] output_tdata;
  logic            output_tvalid;
  logic            output_tready;
  logic [2:0]      state_o;

  int err_cnt = 0;
  int chk_cnt = 0;
  logic [SIZE-1:0] exp_q[$];

  mult_inverse #(.SIZE(SIZE)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .input_base_tdata     (input_base_tdata),
    .input_base_tvalid    (input_base_tvalid),
    .input_base_tready    (input_base_tready),
    .input_modulus_tdata  (input_modulus_tdata),
    .input_modulus_tvalid (input_modulus_tvalid),
    .input_modulus_tready (input_modulus_tready),
    .output_tdata         (output_tdata),
    .output_tvalid        (output_tvalid),
    .output_tready        (output_tready),
    .state_o              (state_o)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: textbook extended Euclid on 64-bit integers
  function automatic logic [SIZE-1:0] ref_inv(input logic [SIZE-1:0] a, input logic [SIZE-1:0] m);
    longint r0, r1, t0, t1, q, tmp;
    if (m <= 1) return '0;
    r0 = longint'(m);
    r1 = longint'(a % m);
    t0 = 0;
    t1 = 1;
    while (r1 != 0) begin
      q   = r0 / r1;
      tmp = r0 - q * r1; r0 = r1; r1 = tmp;
      tmp = t0 - q * t1; t0 = t1; t1 = tmp;
    end
    if (r0 != 1) return '0;
    if (t0 < 0) t0 += longint'(m);
    return SIZE'(t0);
  endfunction

  task automatic scramble_inputs();
    input_base_tdata     = SIZE'($urandom);
    input_modulus_tdata  = SIZE'($urandom);
    input_base_tvalid    = 1'($urandom_range(0, 1));
    input_modulus_tvalid = 1'($urandom_range(0, 1));
  endtask

  // Drive one operation, hold the result for 'hold' cycles, then accept it
  task automatic run_op(input string tag, input logic [SIZE-1:0] a, input logic [SIZE-1:0] m,
                        input logic [SIZE-1:0] exp_val, input int hold);
    int n;
    logic [SIZE-1:0] held, got, exp;
    longint unsigned prod;
    exp_q.push_back(exp_val);
    @(negedge clk);
    input_base_tdata     = a;
    input_modulus_tdata  = m;
    input_base_tvalid    = 1'b1;
    input_modulus_tvalid = 1'b1;
    output_tready        = (hold == 0);
    n = 0;
    while (!(input_base_tready && input_modulus_tready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, " accept"}, 64'(input_base_tready && input_modulus_tready), 1);
    @(posedge clk);
    @(negedge clk);
    check_val({tag, " busy_tready"}, 64'(input_base_tready), 0);
    n = 1;
    while (!output_tvalid && n <= MAX_LAT) begin
      scramble_inputs();
      @(negedge clk);
      n++;
    end
    check_val({tag, " valid"}, 64'(output_tvalid), 1);
    check_val({tag, " lat_min"}, 64'(n >= SIZE + 1), 1);
    check_val({tag, " lat_max"}, 64'(n <= MAX_LAT), 1);
    if (hold > 0) begin
      held = output_tdata;
      repeat (hold) begin
        scramble_inputs();
        @(negedge clk);
      end
      check_val({tag, " hold_valid"}, 64'(output_tvalid), 1);
      check_val({tag, " hold_data"}, 64'(output_tdata), 64'(held));
      check_val({tag, " hold_tready"}, 64'(input_modulus_tready), 0);
    end
    input_base_tvalid    = 1'b0;
    input_modulus_tvalid = 1'b0;
    output_tready        = 1'b1;
    got = output_tdata;
    exp = exp_q.pop_front();
    check_val({tag, " result"}, 64'(got), 64'(exp));
    if (exp != '0) begin
      prod = (longint'(a % m) * longint'(got)) % longint'(m);
      check_val({tag, " a_times_x"}, prod, 1);
    end
    @(posedge clk);
    @(negedge clk);
    check_val({tag, " valid_drop"}, 64'(output_tvalid), 0);
    check_val({tag, " ready_again"}, 64'(input_base_tready), 1);
    check_val({tag, " data_kept"}, 64'(output_tdata), 64'(got));
  endtask

  initial begin : main
    int n, seen;
    logic [SIZE-1:0] a, m;
    rst                  = 1'b0;
    input_base_tdata     = '0;
    input_base_tvalid    = 1'b0;
    input_modulus_tdata  = '0;
    input_modulus_tvalid = 1'b0;
    output_tready        = 1'b1;

    // Reset
    repeat (3) @(negedge clk);
    check_val("rst tready", 64'(input_base_tready | input_modulus_tready), 0);
    check_val("rst valid", 64'(output_tvalid), 0);
    check_val("rst data", 64'(output_tdata), 0);
    check_val("rst state", 64'(state_o), 0);
    rst = 1'b1;
    @(negedge clk);
    check_val("idle tready", 64'(input_base_tready & input_modulus_tready), 1);

    // A lone valid operand must not be captured
    input_base_tdata  = 32'd3;
    input_base_tvalid = 1'b1;
    repeat (5) @(negedge clk);
    check_val("single_valid state", 64'(state_o), 0);
    check_val("single_valid tready", 64'(input_base_tready), 1);
    input_base_tvalid = 1'b0;

    // Directed cases
    run_op("a3m7", 32'd3, 32'd7, 32'd5, 0);
    run_op("a17m3120", 32'd17, 32'd3120, 32'd2753, 0);
    run_op("big", 32'd1435631627, 32'd69814, 32'd22251, 0);
    run_op("gcd2", 32'd10, 32'd4, 32'd0, 0);
    run_op("m1", 32'd5, 32'd1, 32'd0, 0);
    run_op("m0", 32'd5, 32'd0, 32'd0, 0);
    run_op("hold20", 32'd3, 32'd7, 32'd5, 20);
    run_op("a_eq_m", 32'd97, 32'd97, 32'd0, 0);

    // Reset in the middle of an operation
    @(negedge clk);
    input_base_tdata     = 32'd17;
    input_modulus_tdata  = 32'd3120;
    input_base_tvalid    = 1'b1;
    input_modulus_tvalid = 1'b1;
    output_tready        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    input_base_tvalid    = 1'b0;
    input_modulus_tvalid = 1'b0;
    check_val("midrst started", 64'(state_o != 3'd0), 1);
    repeat (40) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("midrst valid", 64'(output_tvalid), 0);
    check_val("midrst state", 64'(state_o), 0);
    check_val("midrst tready", 64'(input_base_tready), 0);
    check_val("midrst data", 64'(output_tdata), 0);
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (output_tvalid) seen++;
    end
    check_val("midrst no_result", 64'(seen), 0);
    check_val("midrst idle", 64'(state_o), 0);
    run_op("post_rst", 32'd3, 32'd7, 32'd5, 0);

    // Randomized operands
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0:       m = SIZE'($urandom_range(0, 3));
        1:       m = SIZE'($urandom_range(2, 1000));
        default: m = SIZE'($urandom);
      endcase
      a = SIZE'($urandom);
      if ($urandom_range(0, 7) == 0) a = m;
      run_op("rand", a, m, ref_inv(a, m), int'($urandom_range(0, 3)));
    end

    n = exp_q.size();
    check_val("queue_empty", 64'(n), 0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
